stream_delay_drain: RTL and testbench
=====================================

Name: stream_delay_drain

Overview:
- Valid/ready stream wrapper around an internal enable-gated shift_reg_bus delay line; it is the consumer-side end of that line.
- It feeds the line, tracks how full the line is, and regenerates an output valid that the line itself lacks.
- At end-of-frame it flushes the line with zero shifts so every accepted sample leaves exactly once, in order, with last on the final beat.
- It sits between pixel-stream stages in the image preprocessing path, where a fixed pipeline delay with backpressure is needed.

Parameters:
- clock_cycles, 32: delay-line depth in shifts. Legal minimum is 2.
- data_width, 16: sample width in bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  data_width  input sample
- s_valid  in  1  input valid
- s_last  in  1  final sample of frame, qualified by s_valid
- s_ready  out  1  input ready
- m_data  out  data_width  delayed sample; driven directly by the delay-line output
- m_valid  out  1  output valid (registered)
- m_last  out  1  final output of frame (registered)
- m_ready  in  1  output ready

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
  - State=IDLE; pc=0; fc=0; m_valid=0; m_last=0.
  - Delay-line contents are not reset and are never emitted, because pc gates m_valid.
- Shift enable, shift = acc | fshift:
  - acc = s_valid & s_ready. Shifts in s_data.
  - fshift = (state==FLUSH) & (fc!=0) & (!m_valid | m_ready). Shifts in zero.
- Line output: after a shift, the line output holds the sample that entered clock_cycles shifts earlier.
- pc: saturating 0..clock_cycles, counts shifts in the current frame.
- m_valid:
  - Set on a shift edge where the post-shift pc equals clock_cycles.
  - Otherwise cleared on m_valid & m_ready with no shift.
  - m_data changes only on shift edges, so it is stable while m_valid=1 and m_ready=0.
- States:
  - IDLE: s_ready=1. acc moves to FILL, or straight to FLUSH if s_last is set.
  - FILL (pc<clock_cycles): s_ready=1, no outputs. Moves to RUN when pc reaches clock_cycles.
  - RUN: s_ready = !m_valid | m_ready. Each acc consumes one output and produces the next.
  - acc with s_last, from IDLE/FILL/RUN: go to FLUSH with fc=clock_cycles-1.
  - FLUSH: s_ready=0. Each fshift decrements fc. The fshift that takes fc from 1 to 0 also sets m_last=1. Then go to LAST.
  - LAST: s_ready=0. On m_valid & m_ready: m_valid=0, m_last=0, pc=0, go to IDLE.
- Latency, with no stalls: first m_valid rises the cycle after the clock_cycles-th accepted sample.
- Short frames (N < clock_cycles): flush shifts still total clock_cycles-1. Outputs start once pc reaches clock_cycles, so exactly N beats are produced.
- Single-sample frame: emits one beat with m_last=1.
- Simultaneous events:
  - RUN, acc and output handshake in the same cycle: the line shifts, m_valid stays 1, m_data takes the next sample.
  - FLUSH, m_ready and fshift together: same rule as above.
- Mid-operation reset: outputs drop immediately. The first frame after reset must see only its own samples.
- Input order is preserved. There is no drop or duplication under any m_ready pattern.

Decomposition:
- Package stream_delay_pkg holds:
  - the state enum IDLE, FILL, RUN, FLUSH, LAST;
  - the function computing the pc/fc width as clog2(clock_cycles+1).
- One sub-module: shift_reg_bus, instantiated as the delay line with data_valid tied to shift.
- Control FSM and counters live in the top module.

Test Plan (clock_cycles=4, data_width=16, sample k = 16'h0100+k):
- 10-sample frame, m_ready=1, s_valid=1 continuous:
  - m_valid rises the cycle after sample 3 is accepted, with m_data=16'h0100.
  - Beats 16'h0100..16'h0109 follow on consecutive cycles.
  - m_last=1 only on 16'h0109; s_ready=0 for 3 flush cycles.
- 2-sample frame, with s_last on sample 1:
  - 3 flush shifts; the first flush shift produces no output.
  - Then 16'h0100, then 16'h0101 with m_last=1.
- Single-sample frame: exactly one beat, 16'h0100 with m_last=1. Back to IDLE after the handshake.
- In RUN, hold m_ready=0 for 5 cycles:
  - s_ready=0, m_valid=1 and m_data stable throughout.
  - Releasing resumes in order with no gap or duplicate.
- Reset mid-RUN after 6 samples, then a fresh 5-sample frame starting at 16'h0200:
  - First output is 16'h0200; no stale 16'h01xx data appears.
- Back-to-back frames with random m_ready:
  - The second frame's first s_ready=1 comes only after the first frame's m_last handshake.
  - The scoreboard matches both frames exactly.

Source files
------------

// File: rtl/stream_delay_pkg.sv
// Shared types and helpers for the stream delay-line wrapper.
package stream_delay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        LAST
    } state_t;

    // Counter width able to hold the value depth itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_reg_bus.sv
// Enable-gated delay line: each data_valid pulse shifts one sample in.
// Contents are deliberately not reset; the consumer gates them out.
module shift_reg_bus #(
    parameter int clock_cycles = 32,
    parameter int data_width   = 16
) (
    input  logic                  clk,
    input  logic                  data_valid,
    input  logic [data_width-1:0] data_in,
    output logic [data_width-1:0] data_out
);

    logic [data_width-1:0] taps [clock_cycles];

    always_ff @(posedge clk) begin
        if (data_valid) begin
            taps[0] <= data_in;
            for (int i = 1; i < clock_cycles; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign data_out = taps[clock_cycles-1];

endmodule

// File: rtl/stream_delay_drain.sv
// Valid/ready wrapper around shift_reg_bus: feeds the line, tracks its fill
// level, regenerates output valid and flushes the line at end of frame.
module stream_delay_drain
    import stream_delay_pkg::*;
#(
    parameter int clock_cycles = 32,
    parameter int data_width   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [data_width-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int CW = cnt_width(clock_cycles);
    localparam logic [CW-1:0] PC_FULL = CW'(clock_cycles);
    localparam logic [CW-1:0] FC_INIT = CW'(clock_cycles - 1);
    localparam logic [CW-1:0] FC_ONE  = CW'(1);

    state_t                state;
    logic [CW-1:0]         pc;
    logic [CW-1:0]         fc;
    logic [CW-1:0]         pc_next;
    logic                  acc;
    logic                  fshift;
    logic                  shift;
    logic [data_width-1:0] line_in;

    always_comb begin
        s_ready = 1'b0;
        case (state)
            IDLE, FILL: s_ready = 1'b1;
            RUN:        s_ready = !m_valid || m_ready;
            default:    s_ready = 1'b0;
        endcase
    end

    assign acc     = s_valid && s_ready;
    assign fshift  = (state == FLUSH) && (fc != '0) && (!m_valid || m_ready);
    assign shift   = acc || fshift;
    // acc and fshift never coincide because s_ready is low while flushing.
    assign line_in = acc ? s_data : '0;
    assign pc_next = (shift && (pc != PC_FULL)) ? pc + 1'b1 : pc;

    shift_reg_bus #(
        .clock_cycles (clock_cycles),
        .data_width   (data_width)
    ) u_line (
        .clk        (clk),
        .data_valid (shift),
        .data_in    (line_in),
        .data_out   (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            fc      <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            pc <= pc_next;

            // The line output is only meaningful once it has seen a full depth of shifts.
            if (shift && (pc_next == PC_FULL)) begin
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (acc) begin
                        if (s_last) begin
                            state <= FLUSH;
                            fc    <= FC_INIT;
                        end else if (pc_next == PC_FULL) begin
                            state <= RUN;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (acc && s_last) begin
                        state <= FLUSH;
                        fc    <= FC_INIT;
                    end else if (pc_next == PC_FULL) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (acc && s_last) begin
                        state <= FLUSH;
                        fc    <= FC_INIT;
                    end
                end
                FLUSH: begin
                    if (fshift) begin
                        fc <= fc - 1'b1;
                        if (fc == FC_ONE) begin
                            m_last <= 1'b1;
                            state  <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (m_valid && m_ready) begin
                        m_last <= 1'b0;
                        pc     <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_delay_drain.sv
// Scoreboard bench for stream_delay_drain with depth 4 and 16-bit samples.
module tb_stream_delay_drain;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    int compared   = 0;
    int mismatched = 0;

    logic [16:0] sb [$];

    int cyc            = 0;
    int beats          = 0;
    int low_flush      = 0;
    int stall_obs      = 0;
    int last_acc_cyc   = 0;
    int last_rise_cyc  = 0;
    int last_mlast_cyc = 0;
    int rise_gap       = 0;
    logic [15:0] rise_data = '0;
    logic        prev_mv   = 1'b0;
    logic        hold      = 1'b0;
    logic [15:0] hold_data = '0;
    logic        tail      = 1'b0;

    int ready_mode  = 0;
    int stall_start = 0;

    stream_delay_drain #(
        .clock_cycles (4),
        .data_width   (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Sole driver of m_ready: always ready, random, or a 5-cycle stall window.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       m_ready = 1'($urandom_range(0, 1));
            2:       m_ready = !((cyc >= stall_start) && (cyc < stall_start + 5));
            default: m_ready = 1'b1;
        endcase
    end

    // Monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            tail    = 1'b0;
            hold    = 1'b0;
            prev_mv = 1'b0;
        end else begin
            if (hold) begin
                checkOutput("hold_m_valid", 32'(m_valid), 32'd1);
                checkOutput("hold_m_data", 32'(m_data), 32'(hold_data));
            end
            if (m_valid && !prev_mv) begin
                last_rise_cyc = cyc;
                rise_gap      = cyc - last_acc_cyc;
                rise_data     = m_data;
            end
            if (tail) checkOutput("tail_s_ready", 32'(s_ready), 32'd0);
            if (!s_ready && !m_last) low_flush++;
            if (ready_mode == 2 && !m_ready) begin
                stall_obs++;
                checkOutput("stall_s_ready", 32'(s_ready), 32'd0);
            end
            if (m_valid && m_ready) begin
                logic [16:0] e;
                beats++;
                checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("m_data", 32'(m_data), 32'(e[15:0]));
                    checkOutput("m_last", 32'(m_last), 32'(e[16]));
                end
                if (m_last) begin
                    last_mlast_cyc = cyc;
                    tail           = 1'b0;
                end
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            if (s_valid && s_ready) begin
                sb.push_back({s_last, s_data});
                last_acc_cyc = cyc;
                if (s_last) tail = 1'b1;
            end
            prev_mv = m_valid;
        end
    end

    // Drives one frame; expects to be entered just after a rising edge.
    task automatic applyStimulus(input int n, input logic [15:0] base, input int stop_after);
        int guard;
        for (int k = 0; k < n; k++) begin
            if (stop_after > 0 && k == stop_after) break;
            s_valid = 1'b1;
            s_data  = base + 16'(k);
            s_last  = (k == n - 1);
            guard   = 0;
            forever begin
                @(negedge clk);
                if (s_ready || guard > 300) break;
                guard++;
            end
            if (guard > 300) begin
                checkOutput("accept_timeout", 32'(guard), 32'd0);
                s_last = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_last = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_valid) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("drain_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int b;
        int l;
        int st;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_m_last", 32'(m_last), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        idle(1);

        $display("[TB] 10-sample frame, continuous ready");
        b = beats; l = low_flush;
        applyStimulus(10, 16'h0100, 0);
        s_valid = 1'b0;
        waitDrain(100);
        checkOutput("f10_beats", 32'(beats - b), 32'd10);
        checkOutput("f10_latency", 32'(rise_gap), 32'd1);
        checkOutput("f10_first_data", 32'(rise_data), 32'h0100);
        checkOutput("f10_consecutive", 32'(last_mlast_cyc - last_rise_cyc), 32'd9);
        checkOutput("f10_flush_cycles", 32'(low_flush - l), 32'd3);
        idle(2);

        $display("[TB] 2-sample frame");
        b = beats; l = low_flush;
        applyStimulus(2, 16'h0100, 0);
        s_valid = 1'b0;
        waitDrain(100);
        checkOutput("f2_beats", 32'(beats - b), 32'd2);
        checkOutput("f2_first_gap", 32'(rise_gap), 32'd3);
        checkOutput("f2_flush_cycles", 32'(low_flush - l), 32'd3);
        idle(2);

        $display("[TB] single-sample frame");
        b = beats; l = low_flush;
        applyStimulus(1, 16'h0100, 0);
        s_valid = 1'b0;
        waitDrain(100);
        checkOutput("f1_beats", 32'(beats - b), 32'd1);
        checkOutput("f1_first_gap", 32'(rise_gap), 32'd4);
        checkOutput("f1_flush_cycles", 32'(low_flush - l), 32'd3);
        checkOutput("f1_idle_ready", 32'(s_ready), 32'd1);
        idle(2);

        $display("[TB] stall in RUN");
        b = beats; st = stall_obs;
        stall_start = cyc + 8;
        ready_mode  = 2;
        applyStimulus(12, 16'h0100, 0);
        s_valid = 1'b0;
        waitDrain(200);
        ready_mode = 0;
        checkOutput("stall_beats", 32'(beats - b), 32'd12);
        checkOutput("stall_cycles", 32'(stall_obs - st), 32'd5);
        idle(2);

        $display("[TB] reset mid-RUN");
        applyStimulus(10, 16'h0100, 6);
        s_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("midreset_m_last", 32'(m_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        b = beats;
        applyStimulus(5, 16'h0200, 0);
        s_valid = 1'b0;
        waitDrain(100);
        checkOutput("postreset_beats", 32'(beats - b), 32'd5);
        checkOutput("postreset_first", 32'(rise_data), 32'h0200);
        idle(2);

        $display("[TB] back-to-back frames, random ready");
        b = beats;
        ready_mode = 1;
        applyStimulus(6, 16'h0300, 0);
        applyStimulus(7, 16'h0400, 0);
        s_valid = 1'b0;
        waitDrain(500);
        ready_mode = 0;
        checkOutput("b2b_beats", 32'(beats - b), 32'd13);
        idle(2);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
